// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit with one-cycle register-file writeback.
// Optional: define MULDIV_EARLY_OUT_EN to skip iteration for zero/overflow cases.
`default_nettype none

module mul_div_unit #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_addr,
    output logic        wr_ena,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        busy
);

    localparam int         ITERS   = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] C_ITERS = 6'(ITERS);
`ifdef MULDIV_EARLY_OUT_EN
    localparam logic C_EARLY_EN = 1'b1;
`else
    localparam logic C_EARLY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_nx;
    logic [5:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_neg_res;
    logic        r_dbz;
    logic [31:0] r_op_a;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_b;
    logic [31:0] r_q;
    logic [32:0] r_rem;

    // Operand decode at accept time
    logic        w_accept, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag;
    logic        w_dbz, w_ovf, w_early, w_take_early, w_neg_res;
    logic [31:0] w_early_data;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_is_div   = funct3[2];
    assign w_a_signed = w_is_div ? ~funct3[0] : (funct3 == 3'd1 || funct3 == 3'd2);
    assign w_b_signed = w_is_div ? ~funct3[0] : (funct3 == 3'd1);
    assign w_a_neg    = w_a_signed && rs1_data[31];
    assign w_b_neg    = w_b_signed && rs2_data[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - rs1_data) : rs1_data;
    assign w_b_mag    = w_b_neg ? (32'd0 - rs2_data) : rs2_data;
    assign w_dbz      = w_is_div && (rs2_data == 32'd0);
    assign w_ovf      = w_is_div && ~funct3[0] && (rs1_data == 32'h8000_0000)
                        && (rs2_data == 32'hFFFF_FFFF);
    assign w_early    = w_dbz || w_ovf
                        || (!w_is_div && (rs1_data == 32'd0 || rs2_data == 32'd0));
    assign w_take_early = C_EARLY_EN && w_early;
    // Remainder follows the dividend sign; product and quotient follow the sign XOR
    assign w_neg_res  = (w_is_div && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    always_comb begin
        w_early_data = 32'd0;
        if (w_dbz)
            w_early_data = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
        else if (w_ovf)
            w_early_data = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration: BITS_PER_CYCLE shift-add or restoring-subtract steps
    logic [63:0] w_acc_nx, w_mcand_nx;
    logic [31:0] w_b_nx, w_q_nx;
    logic [32:0] w_rem_nx;

    always_comb begin
        w_acc_nx   = r_acc;
        w_mcand_nx = r_mcand;
        w_b_nx     = r_b;
        w_q_nx     = r_q;
        w_rem_nx   = r_rem;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_funct3[2]) begin
                w_rem_nx = {w_rem_nx[31:0], w_q_nx[31]};
                w_q_nx   = {w_q_nx[30:0], 1'b0};
                if (w_rem_nx >= {1'b0, r_b}) begin
                    w_rem_nx  = w_rem_nx - {1'b0, r_b};
                    w_q_nx[0] = 1'b1;
                end
            end else begin
                if (w_b_nx[0])
                    w_acc_nx = w_acc_nx + w_mcand_nx;
                w_mcand_nx = w_mcand_nx << 1;
                w_b_nx     = w_b_nx >> 1;
            end
        end
    end

    logic [63:0] w_mag, w_signed;
    logic [31:0] w_result;

    always_comb begin
        if (r_funct3[2])
            w_mag = r_funct3[1] ? {32'd0, w_rem_nx[31:0]} : {32'd0, w_q_nx};
        else
            w_mag = w_acc_nx;
        w_signed = r_neg_res ? (64'd0 - w_mag) : w_mag;
        if (r_dbz)
            w_result = r_funct3[1] ? r_op_a : 32'hFFFF_FFFF;
        else if (!r_funct3[2] && r_funct3[1:0] != 2'd0)
            w_result = w_signed[63:32];
        else
            w_result = w_signed[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept)
                    w_state_nx = w_take_early ? S_DONE : S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == 6'd1)
                    w_state_nx = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 6'd0;
            r_funct3  <= 3'd0;
            r_rd      <= 5'd0;
            r_neg_res <= 1'b0;
            r_dbz     <= 1'b0;
            r_op_a    <= 32'd0;
            r_acc     <= 64'd0;
            r_mcand   <= 64'd0;
            r_b       <= 32'd0;
            r_q       <= 32'd0;
            r_rem     <= 33'd0;
            wr_ena    <= 1'b0;
            wr_addr   <= 5'd0;
            wr_data   <= 32'd0;
        end else begin
            wr_ena <= 1'b0;
            if (w_accept) begin
                r_funct3  <= funct3;
                r_rd      <= rd_addr;
                r_neg_res <= w_neg_res;
                r_dbz     <= w_dbz;
                r_op_a    <= rs1_data;
                r_acc     <= 64'd0;
                r_mcand   <= {32'd0, w_a_mag};
                r_b       <= w_b_mag;
                r_q       <= w_a_mag;
                r_rem     <= 33'd0;
                r_cnt     <= w_take_early ? 6'd0 : C_ITERS;
                if (w_take_early) begin
                    wr_ena  <= (rd_addr != 5'd0);
                    wr_addr <= rd_addr;
                    wr_data <= w_early_data;
                end
            end else if (r_state == S_CALC) begin
                r_acc   <= w_acc_nx;
                r_mcand <= w_mcand_nx;
                r_b     <= w_b_nx;
                r_q     <= w_q_nx;
                r_rem   <= w_rem_nx;
                r_cnt   <= r_cnt - 6'd1;
                if (r_cnt == 6'd1) begin
                    wr_ena  <= (r_rd != 5'd0);
                    wr_addr <= r_rd;
                    wr_data <= w_result;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit at BITS_PER_CYCLE 1 and 4.
`default_nettype none

module tb_mul_div_unit;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  rd_addr;
    logic        in_ready, wr_ena, busy;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        in_ready4, wr_ena4, busy4;
    logic [4:0]  wr_addr4;
    logic [31:0] wr_data4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    mul_div_unit #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
        .wr_ena(wr_ena4), .wr_addr(wr_addr4), .wr_data(wr_data4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issues one op and records, per cycle after accept, what both units write.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd,
                          output logic [31:0] d, output logic [4:0] ad, output int lat,
                          output int pulses, output int rdy,
                          output logic [31:0] d4, output int lat4);
        d = '0; ad = '0; lat = 0; pulses = 0; rdy = 0; d4 = '0; lat4 = 0;
        @(negedge clk);
        funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 60 && rdy == 0; c++) begin
            @(negedge clk);
            if (wr_ena) begin pulses++; lat = c; d = wr_data; ad = wr_addr; end
            if (wr_ena4) begin lat4 = c; d4 = wr_data4; end
            if (in_ready) rdy = c;
        end
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        bit          early;
    } vec_t;

    vec_t vecs[17] = '{
        '{3'd0, 32'd7,          32'd6,          5'd5,  32'd42,         1'b0},
        '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000,  1'b0},
        '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  1'b0},
        '{3'd2, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF,  1'b0},
        '{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,  1'b0},
        '{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  1'b0},
        '{3'd5, 32'd100,        32'd7,          5'd7,  32'd14,         1'b0},
        '{3'd7, 32'd100,        32'd7,          5'd8,  32'd2,          1'b0},
        '{3'd4, 32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF,  1'b1},
        '{3'd6, 32'd5,          32'd0,          5'd10, 32'd5,          1'b1},
        '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000,  1'b1},
        '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0,          1'b1},
        '{3'd0, 32'h1234_5678,  32'd0,          5'd13, 32'd0,          1'b1},
        '{3'd0, 32'hFFFF_FFFD,  32'd5,          5'd14, 32'hFFFF_FFF1,  1'b0},
        '{3'd4, 32'd7,          32'hFFFF_FFFE,  5'd15, 32'hFFFF_FFFD,  1'b0},
        '{3'd6, 32'd7,          32'hFFFF_FFFE,  5'd16, 32'd1,          1'b0},
        '{3'd7, 32'hFFFF_FFF9,  32'd0,          5'd31, 32'hFFFF_FFF9,  1'b1}
    };

    initial begin
        logic [31:0] d, d4;
        logic [4:0]  ad;
        int          lat, pulses, rdy, lat4, exp_lat, exp_lat4, stray;

        rst = 1'b1; in_valid = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_addr = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_busy",     {31'd0, busy},     32'd0);
        check("reset_wr_ena",   {31'd0, wr_ena},   32'd0);
        check("reset_wr_addr",  {27'd0, wr_addr},  32'd0);
        check("reset_wr_data",  wr_data,           32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, d, ad, lat, pulses, rdy, d4, lat4);
            exp_lat  = (vecs[i].early && EO) ? 1 : 33;
            exp_lat4 = (vecs[i].early && EO) ? 1 : 9;
            check($sformatf("v%0d_data", i),    d,               vecs[i].exp);
            check($sformatf("v%0d_addr", i),    {27'd0, ad},     {27'd0, vecs[i].rd});
            check($sformatf("v%0d_pulses", i),  32'(pulses),     32'd1);
            check($sformatf("v%0d_latency", i), 32'(lat),        32'(exp_lat));
            check($sformatf("v%0d_ready", i),   32'(rdy),        32'(exp_lat + 1));
            check($sformatf("v%0d_data4", i),   d4,              vecs[i].exp);
            check($sformatf("v%0d_latency4", i), 32'(lat4),      32'(exp_lat4));
        end

        // Reset in the middle of CALC
        @(negedge clk);
        funct3 = 3'd0; rs1_data = 32'd7; rs2_data = 32'd6; rd_addr = 5'd5; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("calc_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_busy",     {31'd0, busy},     32'd0);
        check("midrst_wr_ena",   {31'd0, wr_ena},   32'd0);
        check("midrst_wr_addr",  {27'd0, wr_addr},  32'd0);
        check("midrst_wr_data",  wr_data,           32'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wr_ena) stray++;
        end
        check("midrst_no_write", 32'(stray), 32'd0);

        run_op(3'd0, 32'd3, 32'd3, 5'd0, d, ad, lat, pulses, rdy, d4, lat4);
        check("x0_pulses", 32'(pulses), 32'd0);
        check("x0_ready",  32'(rdy),    32'd34);

        run_op(3'd5, 32'd9, 32'd3, 5'd17, d, ad, lat, pulses, rdy, d4, lat4);
        check("divu_data",     d,          32'd3);
        check("divu_latency",  32'(lat),   32'd33);
        check("divu_data4",    d4,         32'd3);
        check("divu_latency4", 32'(lat4),  32'd9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide execution unit. It sits between the register file read ports and its write port. It accepts two source operands (fed from `rd_data0`/`rd_data1`), a `funct3` opcode and a destination index. It computes the result over several cycles and drives the register file write channel (`wr_ena`/`wr_addr`/`wr_data`) for exactly one cycle when done. The core stalls on `in_ready` while the unit is busy.

## Interface
Parameters:
- `BITS_PER_CYCLE`, default 1: quotient/multiplier bits retired per iteration. Legal values are 1, 2 and 4. Iteration count is `ITERS = 32/BITS_PER_CYCLE`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept; equals (state == IDLE).
- `funct3`  in  3  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU, 4=DIV, 5=DIVU, 6=REM, 7=REMU.
- `rs1_data`  in  32  operand a (dividend / multiplicand).
- `rs2_data`  in  32  operand b (divisor / multiplier).
- `rd_addr`  in  5  destination register.
- `wr_ena`  out  1  register file write strobe, one-cycle pulse.
- `wr_addr`  out  5  register file write index.
- `wr_data`  out  32  result.
- `busy`  out  1  high in CALC and DONE.

## Operation
- Handshake: an operation is accepted on a rising edge where `in_valid && in_ready`. On accept, `funct3`, `rd_addr` and the operands are captured. Inputs are ignored at all other times.
- States:
  - IDLE: on accept, go to CALC (or DONE under early-out).
  - CALC: runs exactly ITERS cycles, driven by a down-counter, then goes to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- Signed ops use magnitudes internally. The final result is negated when the operand signs differ (quotient/product) or when the dividend is negative (remainder).
- Multiply:
  - Produces the full 64-bit product of the operands, both extended to 33 bits with sign per op: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned×unsigned.
  - MUL returns product[31:0]; the MULH* ops return product[63:32].
- Divide: restoring division, `BITS_PER_CYCLE` quotient bits per cycle. Required results:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `rs1_data`. Sign fix-up is suppressed in this case.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- Writeback:
  - In DONE, `wr_ena` = (captured `rd_addr` != 0), `wr_addr` = captured `rd_addr`, `wr_data` = result.
  - Outside DONE, `wr_ena` = 0. `wr_addr` and `wr_data` hold their last values.
  - An op targeting x0 computes normally but never writes.

## Timing
- Reset (asynchronous): state = IDLE, counter = 0, `in_ready` = 1, `busy` = 0, `wr_ena` = 0, `wr_addr` = 0, `wr_data` = 0.
- Reset during CALC/DONE discards the operation; no write is issued.
- Normal latency: accept at edge E0; CALC covers cycles 1..ITERS; DONE is cycle ITERS+1 with `wr_ena` high; `in_ready` rises in cycle ITERS+2. With the default parameter the result appears 33 cycles after accept.
- Back-to-back: the next op can be accepted on the edge that ends the first cycle with `in_ready` = 1. Sustained throughput is one op per ITERS+2 cycles.
- `in_valid` held high while `in_ready` = 0 has no effect. The request is not queued.
- All outputs are registered except `in_ready` and `busy`, which decode directly from state.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: these cases skip CALC and go IDLE → DONE, writing in cycle 1 after accept (latency 1):
  - divide by zero;
  - signed overflow;
  - any multiply with an operand equal to 0.
- `MULDIV_EARLY_OUT_EN` undefined: every op takes the full ITERS+1 cycles. Results are bit-identical in both builds.

## Test plan
- MUL 7 × 6, rd=5 → `wr_ena` pulse in cycle 33 only, `wr_addr` = 5, `wr_data` = 42. `in_ready` is low in cycles 1–33.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF. REM 5 / 0 → 5. DIV 0x80000000 / −1 → 0x80000000. Latency is 1 with `MULDIV_EARLY_OUT_EN` and 33 without.
- MUL 3 × 3 with rd=0 → no `wr_ena` pulse; `in_ready` returns in cycle 34.
- Assert `rst` in CALC cycle 10 → outputs take reset values immediately, and no write occurs. A new DIVU 9 / 3 issued after reset → 3, with `BITS_PER_CYCLE` = 4 giving the result in cycle 9.
